// File: rtl/add_err_pkg.sv
// add_err_pkg: shared types and defaults for the ADD error/interrupt controller.
//  state_t    - interrupt sequencer states (IDLE, ARM, PEND)
//  CNT_W_DEF  - default width of the error counter
package add_err_pkg;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    PEND = 2'd2
  } state_t;
endpackage

// File: rtl/err_sat_counter.sv
// err_sat_counter: saturating up-counter with synchronous clear.
//  clk  in  clock
//  rst  in  synchronous active-high reset
//  clr  in  clear; when paired with inc the count restarts at 1
//  inc  in  increment request (ignored once saturated)
//  cnt  out registered count
//  sat  out cnt is all-ones
module err_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);
  assign sat = &cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      // an event coinciding with the clear is counted, not lost
      cnt <= inc ? W'(1) : '0;
    else if (inc && !sat)
      cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/add_err_intr_ctrl.sv
// add_err_intr_ctrl: counts uncorrectable errors on ADD requests and sequences a
// level interrupt (IDLE -> ARM -> PEND, held until software acks).
// Optional feature macro: ADD_ERR_LOG_EN (first-error req_id capture).
//  clk, rst       clock / synchronous active-high reset
//  req_valid, req_is_add, uncorr_err  form the error event
//  req_id         request tag, captured on first error when logging is built
//  intr_en        gates new interrupts only
//  intr_ack       clears a pending interrupt
//  cnt_clr        clears err_cnt, intr_ovf and the error log
//  err_cnt, err_cnt_sat  saturating error count and its full flag
//  interrupt      registered level interrupt (state == PEND)
//  intr_ovf       sticky: error arrived while an interrupt was already in flight
//  err_log_vld, err_log_id  first-error capture
module add_err_intr_ctrl
  import add_err_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ID_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_is_add,
  input  logic [ID_W-1:0]  req_id,
  input  logic             uncorr_err,
  input  logic             intr_en,
  input  logic             intr_ack,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_cnt_sat,
  output logic             interrupt,
  output logic             intr_ovf,
  output logic             err_log_vld,
  output logic [ID_W-1:0]  err_log_id
);
  logic   evt;
  state_t state;

  assign evt = req_valid & req_is_add & uncorr_err;

  err_sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (evt),
    .cnt (err_cnt),
    .sat (err_cnt_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      interrupt <= 1'b0;
      intr_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (evt && intr_en) state <= ARM;
        ARM: begin
          state     <= PEND;
          interrupt <= 1'b1;
        end
        PEND: if (intr_ack) begin
          // an ack can be immediately followed by a fresh arm
          state     <= (evt && intr_en) ? ARM : IDLE;
          interrupt <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
      // coalesced event: setting wins over a same-cycle clear
      if (evt && (state == ARM || (state == PEND && !intr_ack)))
        intr_ovf <= 1'b1;
      else if (cnt_clr)
        intr_ovf <= 1'b0;
    end
  end

`ifdef ADD_ERR_LOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_log_vld <= 1'b0;
      err_log_id  <= '0;
    end else if (cnt_clr) begin
      // clear re-opens the log; an event in the same cycle is its first entry
      err_log_vld <= evt;
      err_log_id  <= evt ? req_id : '0;
    end else if (evt && !err_log_vld) begin
      err_log_vld <= 1'b1;
      err_log_id  <= req_id;
    end
  end
`else
  logic unused_req_id;
  assign unused_req_id = ^req_id;
  assign err_log_vld   = 1'b0;
  assign err_log_id    = '0;
`endif
endmodule

// File: tb/tb_add_err_intr_ctrl.sv
module tb_add_err_intr_ctrl;
  localparam int CNT_W = 4;
  localparam int ID_W  = 8;
  localparam int MAX   = (1 << CNT_W) - 1;
`ifdef ADD_ERR_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, req_valid, req_is_add, uncorr_err, intr_en, intr_ack, cnt_clr;
  logic [ID_W-1:0]  req_id;
  logic [CNT_W-1:0] err_cnt;
  logic             err_cnt_sat, interrupt, intr_ovf, err_log_vld;
  logic [ID_W-1:0]  err_log_id;

  always #5 clk = ~clk;

  add_err_intr_ctrl #(.CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_is_add(req_is_add),
    .req_id(req_id), .uncorr_err(uncorr_err), .intr_en(intr_en),
    .intr_ack(intr_ack), .cnt_clr(cnt_clr), .err_cnt(err_cnt),
    .err_cnt_sat(err_cnt_sat), .interrupt(interrupt), .intr_ovf(intr_ovf),
    .err_log_vld(err_log_vld), .err_log_id(err_log_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: an error count, a "raise next cycle" flag and the interrupt level.
  int        m_cnt;
  bit        m_arm, m_intr, m_ovf, m_lvld;
  bit [7:0]  m_lid;

  task automatic model_edge();
    bit e, busy, ack_hit, new_arm;
    e = req_valid & req_is_add & uncorr_err;
    if (rst) begin
      m_cnt = 0; m_arm = 0; m_intr = 0; m_ovf = 0; m_lvld = 0; m_lid = 0;
      return;
    end
    busy    = m_arm || m_intr;
    ack_hit = m_intr && intr_ack;
    if (cnt_clr) m_cnt = e ? 1 : 0;
    else if (e && m_cnt < MAX) m_cnt = m_cnt + 1;
    if (e && busy && !ack_hit) m_ovf = 1;
    else if (cnt_clr) m_ovf = 0;
    new_arm = e && intr_en && (!busy || ack_hit);
    if (m_arm) m_intr = 1;
    else if (ack_hit) m_intr = 0;
    m_arm = new_arm;
    if (LOG) begin
      if (cnt_clr) begin m_lvld = 0; m_lid = 0; end
      if (e && !m_lvld) begin m_lvld = 1; m_lid = req_id; end
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, settle past the edge.
  task automatic drive(input bit r, input bit v, input bit a, input bit u, input bit en,
                       input bit ak, input bit cl, input logic [7:0] id);
    rst = r; req_valid = v; req_is_add = a; uncorr_err = u;
    intr_en = en; intr_ack = ak; cnt_clr = cl; req_id = id;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit rst, vld, add, uerr, en, ack, clr;
    logic [7:0] id;
    int cnt;
    bit intr, ovf, lvld;
    logic [7:0] lid;
  } vec_t;

  vec_t tbl[$];

  task automatic push(input bit r, v, a, u, en, ak, cl, input logic [7:0] id,
                      input int cnt, input bit intr, ovf, lvld, input logic [7:0] lid);
    vec_t t;
    t.rst = r; t.vld = v; t.add = a; t.uerr = u; t.en = en; t.ack = ak; t.clr = cl;
    t.id = id; t.cnt = cnt; t.intr = intr; t.ovf = ovf; t.lvld = lvld; t.lid = lid;
    tbl.push_back(t);
  endtask

  initial begin
    // rst vld add uerr en ack clr id  | cnt intr ovf lvld lid
    push(1,0,0,0,0,0,0,8'h00, 0,0,0,0,8'h00); // reset
    push(0,0,0,0,1,0,0,8'h00, 0,0,0,0,8'h00);
    push(0,1,0,1,1,0,0,8'h00, 0,0,0,0,8'h00); // non-ADD error: ignored
    push(0,1,1,1,1,0,0,8'h12, 1,0,0,1,8'h12); // evt -> ARM
    push(0,0,0,0,1,0,0,8'h00, 1,1,0,1,8'h12); // PEND
    push(0,0,0,0,1,0,0,8'h00, 1,1,0,1,8'h12);
    push(0,0,0,0,1,1,0,8'h00, 1,0,0,1,8'h12); // ack -> IDLE
    push(0,1,1,1,1,0,0,8'h22, 2,0,0,1,8'h12); // back-to-back evts
    push(0,1,1,1,1,0,0,8'h34, 3,1,1,1,8'h12); // evt in ARM: coalesced
    push(0,0,0,0,1,0,0,8'h00, 3,1,1,1,8'h12);
    push(0,0,0,0,1,1,0,8'h00, 3,0,1,1,8'h12);
    push(0,0,0,0,1,0,1,8'h00, 0,0,0,0,8'h00); // cnt_clr
    push(0,1,1,1,0,0,0,8'h56, 1,0,0,1,8'h56); // intr_en=0: counted only
    push(0,1,1,1,0,0,0,8'h57, 2,0,0,1,8'h56);
    push(0,1,1,1,0,0,0,8'h58, 3,0,0,1,8'h56);
    push(0,0,0,0,0,0,0,8'h00, 3,0,0,1,8'h56);
    push(0,1,1,1,1,0,0,8'h60, 4,0,0,1,8'h56); // ARM
    push(0,0,0,0,0,1,0,8'h00, 4,1,0,1,8'h56); // ack in ARM ignored, en drop keeps ARM
    push(0,1,1,1,1,1,0,8'h61, 5,0,0,1,8'h56); // ack+evt in PEND -> re-ARM
    push(0,0,0,0,1,0,0,8'h00, 5,1,0,1,8'h56);
    push(0,0,0,0,1,1,0,8'h00, 5,0,0,1,8'h56);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      t = tbl[i];
      drive(t.rst, t.vld, t.add, t.uerr, t.en, t.ack, t.clr, t.id);
      chk($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(t.cnt));
      chk($sformatf("vec%0d err_cnt_sat", i), 32'(err_cnt_sat), 32'(t.cnt == MAX));
      chk($sformatf("vec%0d interrupt", i), 32'(interrupt), 32'(t.intr));
      chk($sformatf("vec%0d intr_ovf", i), 32'(intr_ovf), 32'(t.ovf));
      chk($sformatf("vec%0d err_log_vld", i), 32'(err_log_vld), 32'(LOG & t.lvld));
      chk($sformatf("vec%0d err_log_id", i), 32'(err_log_id), LOG ? 32'(t.lid) : 32'h0);
    end

    // Saturation: 17 events on a 4-bit counter stop at 15.
    drive(0,0,0,0,0,0,1,8'h00);
    chk("sat clr", 32'(err_cnt), 32'h0);
    for (int i = 1; i <= 17; i++) begin
      drive(0,1,1,1,0,0,0,8'h00);
      chk($sformatf("sat evt%0d cnt", i), 32'(err_cnt), 32'(i < MAX ? i : MAX));
      chk($sformatf("sat evt%0d flag", i), 32'(err_cnt_sat), 32'(i >= MAX));
    end
    drive(0,1,1,1,0,0,1,8'h00);
    chk("clr+evt cnt", 32'(err_cnt), 32'h1);
    chk("clr+evt sat", 32'(err_cnt_sat), 32'h0);

    // Reset while ARM discards the pending interrupt.
    drive(0,1,1,1,1,0,0,8'h77);
    chk("arm cnt", 32'(err_cnt), 32'h2);
    chk("arm intr", 32'(interrupt), 32'h0);
    drive(1,0,0,0,1,0,0,8'h00);
    chk("rst-in-arm cnt", 32'(err_cnt), 32'h0);
    chk("rst-in-arm intr", 32'(interrupt), 32'h0);
    chk("rst-in-arm ovf", 32'(intr_ovf), 32'h0);
    chk("rst-in-arm lvld", 32'(err_log_vld), 32'h0);
    chk("rst-in-arm lid", 32'(err_log_id), 32'h0);
    drive(0,0,0,0,1,0,0,8'h00);
    chk("post-rst intr", 32'(interrupt), 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0,59) == 0, 1'($urandom), $urandom_range(0,3) != 0,
            1'($urandom), $urandom_range(0,3) != 0, $urandom_range(0,2) == 0,
            $urandom_range(0,24) == 0, 8'($urandom));
      chk($sformatf("rnd%0d err_cnt", c), 32'(err_cnt), 32'(m_cnt));
      chk($sformatf("rnd%0d err_cnt_sat", c), 32'(err_cnt_sat), 32'(m_cnt == MAX));
      chk($sformatf("rnd%0d interrupt", c), 32'(interrupt), 32'(m_intr));
      chk($sformatf("rnd%0d intr_ovf", c), 32'(intr_ovf), 32'(m_ovf));
      chk($sformatf("rnd%0d err_log_vld", c), 32'(err_log_vld), 32'(m_lvld));
      chk($sformatf("rnd%0d err_log_id", c), 32'(err_log_id), 32'(m_lid));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
